control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multicycle FSM that drives every control wire of the cpu datapath: PC, memory, IR, register bank, A/B, ALU, ALUOut, EPC and all muxes.
- Sits opposite the datapath. It consumes IR fields and ALU flags, and produces the datapath's control inputs.
- Covers fetch/decode, the R/I/J instruction subset below, and the opcode and overflow exception sequences.

Parameters:
- MEM_WAIT, 1, number of wait cycles between presenting a memory read address and its data being valid (range 1..3).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- OPCODE  in  6  IR[31:26]
- funct  in  6  IR[5:0] (OFFSET[5:0])
- Overflow  in  1  ALU overflow
- branch_taken  in  1  mux_aluLogic output
- PC_write, MEMRead, IRWrite, MDR_load, RegWrite, A_load, B_load, AluOutWrite, EPCWrite  out  1 each  load/write strobes; MEMRead 0 = read, 1 = write
- ALU_control  out  3  000 loadA, 001 add, 010 sub, 011 and, 100 inc, 101 not, 110 xor, 111 compare
- ALULogic  out  2  00 zero, 01 ~zero, 10 GT, 11 ~GT
- IorD  out  3  000 PC, 001 A, 010 B, 011 ALUOut, 100 const 253, 101 const 254
- RegDst  out  2  00 rt, 01 rd, 10 const 31
- MenToReg  out  3  000 ALUOut, 011 SE1_32(LT), 101 LS_out
- ALUSourceA  out  2  00 PC, 01 A, 10 MDR
- ALUSourceB  out  3  000 B, 001 const 4, 010 SE16, 011 SL2(SE16)
- PCSource  out  3  000 ALU_result, 001 ALUOut, 010 EPC, 011 jump concat, 100 LS_out, 101 A
- ls_sel  out  2  load_size select: 00 word, 10 byte
- state_out  out  6  current state encoding, for verification only

Behaviour:
- Reset:
  - reset high at a clk edge sets state = RESET.
  - In RESET every output is 0, strobes and selects alike. Any unlisted output is 0 in every state.
  - RESET always goes to FETCH0. Reset mid-instruction aborts it, and no strobe fires in the reset cycle.
- Output style: Moore outputs from the registered state, except PC_write in BR, which equals branch_taken (Mealy).
- Fetch and decode:
  - FETCH0: IorD=000, MEMRead=0.
  - FETCH_W: MEM_WAIT cycles, selects held.
  - FETCH2: IRWrite=1; ALUSourceA=00, ALUSourceB=001, ALU_control=001, PCSource=000, PC_write=1 (PC <= PC+4).
  - DECODE: A_load=B_load=1; ALUSourceA=00, ALUSourceB=011, add, AluOutWrite=1 (branch target). Next state by opcode/funct.
- R-type (OPCODE 0x00):
  - funct 0x20 add, 0x22 sub, 0x24 and go to R_EX: ALUSourceA=01, ALUSourceB=000, ALU op per funct, AluOutWrite=1.
  - From R_EX: Overflow=1 on add/sub goes to EXC0 (cause OVF); otherwise R_WB: RegDst=01, MenToReg=000, RegWrite=1, then FETCH0.
  - funct 0x2A slt goes to SLT_WB, a single state: ALUSourceA=01, ALUSourceB=000, compare, RegDst=01, MenToReg=011, RegWrite=1.
  - funct 0x08 jr goes to JR: PCSource=101, PC_write=1.
- ADDI 0x08: I_EX uses ALUSourceB=010 and add, with the same overflow rule as R_EX. I_WB: RegDst=00, RegWrite=1.
- LW 0x23:
  - ADDR: A+SE16, AluOutWrite=1.
  - LW_RD: IorD=011, read, then MEM_WAIT wait cycles.
  - LW_MDR: MDR_load=1.
  - LW_WB: MenToReg=101, ls_sel=00, RegDst=00, RegWrite=1.
- SW 0x2B: ADDR, then SW_WR: IorD=011, MEMRead=1 for exactly one cycle, then FETCH0.
- Branches BEQ 0x04 / BNE 0x05 / BLE 0x06 / BGT 0x07:
  - BR: ALUSourceA=01, ALUSourceB=000, compare, ALULogic 00/01/11/10 respectively.
  - PCSource=001, PC_write=branch_taken.
- Jumps:
  - J 0x02: PCSource=011, PC_write=1.
  - JAL 0x03: JAL0 runs ALUSourceA=00, ALU loadA, AluOutWrite=1. JAL1 runs RegDst=10, MenToReg=000, RegWrite=1, PCSource=011, PC_write=1.
- Any other OPCODE, or unlisted funct, goes from DECODE to EXC0 with cause OPC.
- Exception sequence (cause held in an internal register):
  - EXC0: ALUSourceA=00, ALUSourceB=001, sub, AluOutWrite=1 (PC-4).
  - EXC1: EPCWrite=1; IorD=100 for OPC or 101 for OVF; read.
  - Then MEM_WAIT wait cycles.
  - EXC_MDR: MDR_load=1.
  - EXC_JMP: ls_sel=10, PCSource=100, PC_write=1, then FETCH0.
- Rule on strobes: overflow aborts the writeback, so RegWrite is never asserted for an overflowing instruction. Every instruction ends in FETCH0.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encodings;
  - opcode and funct constants;
  - every mux-select and ALU_control encoding listed above, which the mux modules must share.
- One sub-module, ctrl_decode: combinational OPCODE/funct to next-after-DECODE state plus an invalid flag. The FSM and output decode stay in control_unit.

Test Plan:
- Reset held 3 cycles mid-LW, then released -> all outputs 0 during reset; state_out = FETCH0 one cycle after RESET; no RegWrite.
- add (OPCODE 0, funct 0x20), MEM_WAIT=1 -> IRWrite at cycle 3, RegWrite exactly once at cycle 6 with RegDst=01; PC_write only at FETCH2.
- add with Overflow=1 in R_EX -> no RegWrite; EXC0..EXC_JMP sequence with IorD=101, EPCWrite once, final PCSource=100, ls_sel=10.
- OPCODE 0x3F -> DECODE then EXC0; IorD=100 in EXC1.
- beq with branch_taken=1, then again with 0 -> PC_write 1 and 0 respectively in BR with PCSource=001, ALULogic=00; bgt drives ALULogic=10.
- sw followed by lw at MEM_WAIT=2 -> MEMRead=1 for exactly one cycle; lw RegWrite with MenToReg=101 after two wait cycles.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state encodings, opcode/funct constants and datapath select encodings
package cpu_ctrl_pkg;

    typedef enum logic [5:0] {
        S_RESET   = 6'd0,
        S_FETCH0, S_FETCH_W, S_FETCH2, S_DECODE,
        S_R_EX, S_R_WB, S_SLT_WB, S_JR,
        S_I_EX, S_I_WB,
        S_ADDR, S_LW_RD, S_LW_W, S_LW_MDR, S_LW_WB, S_SW_WR,
        S_BR, S_J, S_JAL0, S_JAL1,
        S_EXC0, S_EXC1, S_EXC_W, S_EXC_MDR, S_EXC_JMP
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BLE  = 6'h06;
    localparam logic [5:0] OP_BGT  = 6'h07;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [2:0] ALU_LOADA = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_INC   = 3'b100;
    localparam logic [2:0] ALU_NOT   = 3'b101;
    localparam logic [2:0] ALU_XOR   = 3'b110;
    localparam logic [2:0] ALU_CMP   = 3'b111;

    localparam logic [1:0] LG_ZERO  = 2'b00;
    localparam logic [1:0] LG_NZERO = 2'b01;
    localparam logic [1:0] LG_GT    = 2'b10;
    localparam logic [1:0] LG_NGT   = 2'b11;

    localparam logic [2:0] IOD_PC     = 3'b000;
    localparam logic [2:0] IOD_A      = 3'b001;
    localparam logic [2:0] IOD_B      = 3'b010;
    localparam logic [2:0] IOD_ALUOUT = 3'b011;
    localparam logic [2:0] IOD_253    = 3'b100;
    localparam logic [2:0] IOD_254    = 3'b101;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_31 = 2'b10;

    localparam logic [2:0] M2R_ALUOUT = 3'b000;
    localparam logic [2:0] M2R_LT     = 3'b011;
    localparam logic [2:0] M2R_LS     = 3'b101;

    localparam logic [1:0] SA_PC  = 2'b00;
    localparam logic [1:0] SA_A   = 2'b01;
    localparam logic [1:0] SA_MDR = 2'b10;

    localparam logic [2:0] SB_B    = 3'b000;
    localparam logic [2:0] SB_4    = 3'b001;
    localparam logic [2:0] SB_SE16 = 3'b010;
    localparam logic [2:0] SB_SL2  = 3'b011;

    localparam logic [2:0] PCS_ALU    = 3'b000;
    localparam logic [2:0] PCS_ALUOUT = 3'b001;
    localparam logic [2:0] PCS_EPC    = 3'b010;
    localparam logic [2:0] PCS_JUMP   = 3'b011;
    localparam logic [2:0] PCS_LS     = 3'b100;
    localparam logic [2:0] PCS_A      = 3'b101;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_BYTE = 2'b10;

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        return f == F_SUB ? ALU_SUB : f == F_AND ? ALU_AND : ALU_ADD;
    endfunction

    function automatic logic [1:0] br_logic(input logic [5:0] op);
        return op == OP_BEQ ? LG_ZERO : op == OP_BNE ? LG_NZERO : op == OP_BLE ? LG_NGT : LG_GT;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: maps OPCODE/funct to the state following DECODE, flagging unsupported encodings
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [5:0] next_state,
    output logic       invalid
);

    // anything not recognised falls through to the exception entry state
    always_comb begin
        next_state = S_EXC0;
        case (opcode)
            OP_R: begin
                case (funct)
                    F_ADD, F_SUB, F_AND: next_state = S_R_EX;
                    F_SLT:               next_state = S_SLT_WB;
                    F_JR:                next_state = S_JR;
                    default:             next_state = S_EXC0;
                endcase
            end
            OP_ADDI:                        next_state = S_I_EX;
            OP_LW, OP_SW:                   next_state = S_ADDR;
            OP_BEQ, OP_BNE, OP_BLE, OP_BGT: next_state = S_BR;
            OP_J:                           next_state = S_J;
            OP_JAL:                         next_state = S_JAL0;
            default:                        next_state = S_EXC0;
        endcase
    end

    assign invalid = next_state == S_EXC0;

endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle FSM driving every datapath control wire, including exception entry
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] funct,
    input  logic       Overflow,
    input  logic       branch_taken,
    output logic       PC_write,
    output logic       MEMRead,
    output logic       IRWrite,
    output logic       MDR_load,
    output logic       RegWrite,
    output logic       A_load,
    output logic       B_load,
    output logic       AluOutWrite,
    output logic       EPCWrite,
    output logic [2:0] ALU_control,
    output logic [1:0] ALULogic,
    output logic [2:0] IorD,
    output logic [1:0] RegDst,
    output logic [2:0] MenToReg,
    output logic [1:0] ALUSourceA,
    output logic [2:0] ALUSourceB,
    output logic [2:0] PCSource,
    output logic [1:0] ls_sel,
    output logic [5:0] state_out
);

    localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT - 1);

    state_t     state;
    logic [1:0] wcnt;
    logic       cause_ovf;
    logic [5:0] dec_next;
    logic       dec_invalid;
    logic       ovf_abort;

    ctrl_decode u_dec (
        .opcode     (OPCODE),
        .funct      (funct),
        .next_state (dec_next),
        .invalid    (dec_invalid)
    );

    // and never overflows; add, sub and addi do, and abort their writeback
    assign ovf_abort = Overflow && (state == S_I_EX || funct != F_AND);

    // state sequencing, memory wait counter and exception cause
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RESET;
            wcnt      <= '0;
            cause_ovf <= 1'b0;
        end else begin
            wcnt <= wcnt - 2'd1;
            case (state)
                S_RESET:   state <= S_FETCH0;
                S_FETCH0:  begin state <= S_FETCH_W; wcnt <= WAIT_LAST; end
                S_FETCH_W: if (wcnt == 2'd0) state <= S_FETCH2;
                S_FETCH2:  state <= S_DECODE;
                S_DECODE:  begin
                    state     <= dec_invalid ? S_EXC0 : state_t'(dec_next);
                    cause_ovf <= 1'b0;
                end
                S_R_EX, S_I_EX: begin
                    if (ovf_abort) begin
                        state     <= S_EXC0;
                        cause_ovf <= 1'b1;
                    end else begin
                        state <= state == S_R_EX ? S_R_WB : S_I_WB;
                    end
                end
                S_ADDR:    state <= OPCODE == OP_SW ? S_SW_WR : S_LW_RD;
                S_LW_RD:   begin state <= S_LW_W; wcnt <= WAIT_LAST; end
                S_LW_W:    if (wcnt == 2'd0) state <= S_LW_MDR;
                S_LW_MDR:  state <= S_LW_WB;
                S_JAL0:    state <= S_JAL1;
                S_EXC0:    state <= S_EXC1;
                S_EXC1:    begin state <= S_EXC_W; wcnt <= WAIT_LAST; end
                S_EXC_W:   if (wcnt == 2'd0) state <= S_EXC_MDR;
                S_EXC_MDR: state <= S_EXC_JMP;
                default:   state <= S_FETCH0;
            endcase
        end
    end

    // Moore decode of the state; reset forces everything quiet, PC_write in BR follows branch_taken
    always_comb begin
        {PC_write, MEMRead, IRWrite, MDR_load, RegWrite, A_load, B_load, AluOutWrite, EPCWrite} = '0;
        ALU_control = ALU_LOADA;
        ALULogic    = LG_ZERO;
        IorD        = IOD_PC;
        RegDst      = RD_RT;
        MenToReg    = M2R_ALUOUT;
        ALUSourceA  = SA_PC;
        ALUSourceB  = SB_B;
        PCSource    = PCS_ALU;
        ls_sel      = LS_WORD;
        state_out   = reset ? 6'd0 : state;
        if (!reset) begin
            case (state)
                S_FETCH2:  begin IRWrite = 1'b1; ALUSourceB = SB_4; ALU_control = ALU_ADD; PC_write = 1'b1; end
                S_DECODE:  begin A_load = 1'b1; B_load = 1'b1; ALUSourceB = SB_SL2; ALU_control = ALU_ADD; AluOutWrite = 1'b1; end
                S_R_EX:    begin ALUSourceA = SA_A; ALU_control = r_alu(funct); AluOutWrite = 1'b1; end
                S_R_WB:    begin RegDst = RD_RD; RegWrite = 1'b1; end
                S_SLT_WB:  begin ALUSourceA = SA_A; ALU_control = ALU_CMP; RegDst = RD_RD; MenToReg = M2R_LT; RegWrite = 1'b1; end
                S_JR:      begin PCSource = PCS_A; PC_write = 1'b1; end
                S_I_EX, S_ADDR: begin ALUSourceA = SA_A; ALUSourceB = SB_SE16; ALU_control = ALU_ADD; AluOutWrite = 1'b1; end
                S_I_WB:    RegWrite = 1'b1;
                S_LW_RD, S_LW_W: IorD = IOD_ALUOUT;
                S_LW_MDR, S_EXC_MDR: MDR_load = 1'b1;
                S_LW_WB:   begin MenToReg = M2R_LS; RegWrite = 1'b1; end
                S_SW_WR:   begin IorD = IOD_ALUOUT; MEMRead = 1'b1; end
                S_BR:      begin ALUSourceA = SA_A; ALU_control = ALU_CMP; ALULogic = br_logic(OPCODE); PCSource = PCS_ALUOUT; PC_write = branch_taken; end
                S_J:       begin PCSource = PCS_JUMP; PC_write = 1'b1; end
                S_JAL0:    begin ALU_control = ALU_LOADA; AluOutWrite = 1'b1; end
                S_JAL1:    begin RegDst = RD_31; RegWrite = 1'b1; PCSource = PCS_JUMP; PC_write = 1'b1; end
                S_EXC0:    begin ALUSourceB = SB_4; ALU_control = ALU_SUB; AluOutWrite = 1'b1; end
                S_EXC1:    begin EPCWrite = 1'b1; IorD = cause_ovf ? IOD_254 : IOD_253; end
                S_EXC_W:   IorD = cause_ovf ? IOD_254 : IOD_253;
                S_EXC_JMP: begin ls_sel = LS_BYTE; PCSource = PCS_LS; PC_write = 1'b1; end
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of control_unit sequencing and strobes at MEM_WAIT 1 and 2
module tb_control_unit;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, reset_2, Overflow, branch_taken;
    logic [5:0] OPCODE, funct;

    logic PC_write, MEMRead, IRWrite, MDR_load, RegWrite, A_load, B_load, AluOutWrite, EPCWrite;
    logic [2:0] ALU_control, IorD, MenToReg, ALUSourceB, PCSource;
    logic [1:0] ALULogic, RegDst, ALUSourceA, ls_sel;
    logic [5:0] state_out;

    logic PC_write_2, MEMRead_2, IRWrite_2, MDR_load_2, RegWrite_2, A_load_2, B_load_2, AluOutWrite_2, EPCWrite_2;
    logic [2:0] ALU_control_2, IorD_2, MenToReg_2, ALUSourceB_2, PCSource_2;
    logic [1:0] ALULogic_2, RegDst_2, ALUSourceA_2, ls_sel_2;
    logic [5:0] state_out_2;

    logic [31:0] outs;
    assign outs = {PC_write, MEMRead, IRWrite, MDR_load, RegWrite, A_load, B_load, AluOutWrite, EPCWrite,
                   ALU_control, ALULogic, IorD, RegDst, MenToReg, ALUSourceA, ALUSourceB, PCSource, ls_sel};

    int checks = 0;
    int failures = 0;

    control_unit #(.MEM_WAIT(1)) dut (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .funct(funct), .Overflow(Overflow), .branch_taken(branch_taken),
        .PC_write(PC_write), .MEMRead(MEMRead), .IRWrite(IRWrite), .MDR_load(MDR_load), .RegWrite(RegWrite),
        .A_load(A_load), .B_load(B_load), .AluOutWrite(AluOutWrite), .EPCWrite(EPCWrite),
        .ALU_control(ALU_control), .ALULogic(ALULogic), .IorD(IorD), .RegDst(RegDst), .MenToReg(MenToReg),
        .ALUSourceA(ALUSourceA), .ALUSourceB(ALUSourceB), .PCSource(PCSource), .ls_sel(ls_sel), .state_out(state_out)
    );

    control_unit #(.MEM_WAIT(2)) dut_2 (
        .clk(clk), .reset(reset_2), .OPCODE(OPCODE), .funct(funct), .Overflow(Overflow), .branch_taken(branch_taken),
        .PC_write(PC_write_2), .MEMRead(MEMRead_2), .IRWrite(IRWrite_2), .MDR_load(MDR_load_2), .RegWrite(RegWrite_2),
        .A_load(A_load_2), .B_load(B_load_2), .AluOutWrite(AluOutWrite_2), .EPCWrite(EPCWrite_2),
        .ALU_control(ALU_control_2), .ALULogic(ALULogic_2), .IorD(IorD_2), .RegDst(RegDst_2), .MenToReg(MenToReg_2),
        .ALUSourceA(ALUSourceA_2), .ALUSourceB(ALUSourceB_2), .PCSource(PCSource_2), .ls_sel(ls_sel_2), .state_out(state_out_2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; reset_2 = 1'b1; Overflow = 1'b0; branch_taken = 1'b0;
        OPCODE = 6'h23; funct = 6'h00;
        tick(2);
        chk("rst_outs", outs, 32'h0);
        chk("rst_state", state_out, S_RESET);
        reset = 1'b0;
        tick(1);
        chk("lw_fetch0", state_out, S_FETCH0);
        tick(2);
        chk("lw_irwrite", IRWrite, 1);
        tick(3);
        chk("lw_rd_iord", IorD, 3'b011);
        reset = 1'b1;
        #1;
        chk("rst_mid_outs", outs, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_hold_outs", outs, 32'h0);
            chk("rst_hold_state", state_out, 6'd0);
        end
        reset = 1'b0;
        tick(1);
        chk("rst_to_fetch0", state_out, S_FETCH0);

        OPCODE = 6'h00; funct = 6'h20;
        for (int c = 1; c <= 6; c++) begin
            chk("add_irwrite", IRWrite, c == 3);
            chk("add_pcwrite", PC_write, c == 3);
            chk("add_regwrite", RegWrite, c == 6);
            if (c == 6) chk("add_regdst", RegDst, 2'b01);
            tick(1);
        end
        chk("add_done", state_out, S_FETCH0);

        tick(4);
        chk("ovf_rex", state_out, S_R_EX);
        chk("ovf_rex_alu", ALU_control, 3'b001);
        Overflow = 1'b1;
        tick(1);
        Overflow = 1'b0;
        chk("ovf_exc0", state_out, S_EXC0);
        chk("ovf_exc0_alu", ALU_control, 3'b010);
        chk("ovf_exc0_aluout", AluOutWrite, 1);
        chk("ovf_exc0_regwrite", RegWrite, 0);
        tick(1);
        chk("ovf_exc1_epc", EPCWrite, 1);
        chk("ovf_exc1_iord", IorD, 3'b101);
        tick(1);
        chk("ovf_wait_epc", EPCWrite, 0);
        chk("ovf_wait_iord", IorD, 3'b101);
        tick(1);
        chk("ovf_mdr", MDR_load, 1);
        chk("ovf_mdr_regwrite", RegWrite, 0);
        tick(1);
        chk("ovf_jmp_pcsrc", PCSource, 3'b100);
        chk("ovf_jmp_ls", ls_sel, 2'b10);
        chk("ovf_jmp_pcw", PC_write, 1);
        tick(1);
        chk("ovf_done", state_out, S_FETCH0);

        OPCODE = 6'h3F;
        tick(3);
        chk("opc_decode", state_out, S_DECODE);
        tick(1);
        chk("opc_exc0", state_out, S_EXC0);
        tick(1);
        chk("opc_exc1_iord", IorD, 3'b100);
        tick(4);
        chk("opc_done", state_out, S_FETCH0);

        OPCODE = 6'h04; branch_taken = 1'b1;
        tick(4);
        chk("beq_t_state", state_out, S_BR);
        chk("beq_t_pcw", PC_write, 1);
        chk("beq_pcsrc", PCSource, 3'b001);
        chk("beq_logic", ALULogic, 2'b00);
        chk("beq_alu", ALU_control, 3'b111);
        tick(1);
        branch_taken = 1'b0;
        tick(4);
        chk("beq_nt_state", state_out, S_BR);
        chk("beq_nt_pcw", PC_write, 0);
        tick(1);
        OPCODE = 6'h07;
        tick(4);
        chk("bgt_logic", ALULogic, 2'b10);
        branch_taken = 1'b1;
        #1;
        chk("bgt_mealy_pcw", PC_write, 1);
        branch_taken = 1'b0;
        tick(1);

        OPCODE = 6'h03;
        tick(4);
        chk("jal0_aluout", AluOutWrite, 1);
        tick(1);
        chk("jal1_regdst", RegDst, 2'b10);
        chk("jal1_regwrite", RegWrite, 1);
        chk("jal1_pcsrc", PCSource, 3'b011);
        tick(1);
        chk("jal_done", state_out, S_FETCH0);

        reset = 1'b1;
        OPCODE = 6'h2B;
        reset_2 = 1'b0;
        tick(1);
        for (int c = 1; c <= 7; c++) begin
            chk("sw_memread", MEMRead_2, c == 7);
            if (c == 7) chk("sw_iord", IorD_2, 3'b011);
            tick(1);
        end
        chk("sw_done", state_out_2, S_FETCH0);
        chk("sw_after_memread", MEMRead_2, 0);

        OPCODE = 6'h23;
        for (int c = 1; c <= 11; c++) begin
            chk("lw_regwrite", RegWrite_2, c == 11);
            chk("lw_mdr", MDR_load_2, c == 10);
            chk("lw_memread", MEMRead_2, 0);
            if (c == 8 || c == 9) chk("lw_wait_iord", IorD_2, 3'b011);
            if (c == 11) chk("lw_m2r", MenToReg_2, 3'b101);
            tick(1);
        end
        chk("lw_done", state_out_2, S_FETCH0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
